// File: rtl/uart_debug_link.sv
// uart_debug_link: byte-stream debug command engine (memory/code/debug-register access, LEDs, processor reset/continue); optional burst checksum via UART_DEBUG_LINK_CHECKSUM_EN
module uart_debug_link #(
    parameter int WORD_SIZE    = 18,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT_CLKS = 5000000
) (
    input  logic                  clk_50M,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  tx_valid,
    output logic [7:0]            tx_byte,
    input  logic                  tx_ready,
    output logic [1:0]            mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic [7:0]            leds,
    output logic                  processor_reset,
    output logic                  continue_pulse,
    output logic                  busy
);
    localparam int AB = (ADDR_WIDTH + 7) / 8;
    localparam int NB = (WORD_SIZE + 7) / 8;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
`ifdef UART_DEBUG_LINK_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef enum logic [3:0] {IDLE, ADDR, SIZE, EXEC, WR_DATA, WR_CSUM, RD_ISSUE, RD_WAIT, RD_SEND, CS_SEND} state_t;

    state_t          state;
    logic [7:0]      cmd, csum;
    logic [15:0]     size, sz_n;
    logic [2:0]      cnt;
    logic [TW-1:0]   tmo;
    logic [AB*8-1:0] abuf, ab_n;
    logic [NB*8-1:0] wbuf, wb_n;
    logic [NB*8+7:0] sh, rd_ext;
    logic            tmo_run, is_wr, is_rd;

    assign ab_n    = (AB*8)'({rx_byte, abuf} >> 8);
    assign wb_n    = (NB*8)'({rx_byte, wbuf} >> 8);
    assign sz_n    = {rx_byte, size[15:8]};
    assign rd_ext  = (NB*8+8)'(mem_rdata);
    assign tmo_run = state inside {ADDR, SIZE, WR_DATA, WR_CSUM};
    assign is_wr   = cmd == 8'd1 || cmd == 8'd3;
    assign is_rd   = cmd == 8'd2 || cmd == 8'd4 || cmd == 8'd6;
    assign busy    = state != IDLE;

    // Command sequencer: header parsing, write/read bursts, checksum reply and inter-byte timeout abort
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            leds            <= '0;
            processor_reset <= 1'b1;
            tx_valid        <= 1'b0;
            tx_byte         <= '0;
            mem_wren        <= 1'b0;
            mem_rden        <= 1'b0;
            continue_pulse  <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_sel         <= '0;
            cmd             <= '0;
            csum            <= '0;
            size            <= '0;
            cnt             <= '0;
            tmo             <= '0;
            abuf            <= '0;
            wbuf            <= '0;
            sh              <= '0;
        end else begin
            continue_pulse <= 1'b0;
            mem_rden       <= 1'b0;
            if (rx_valid)
                tmo <= TW'(TIMEOUT_CLKS);
            else if (tmo_run && tmo != '0)
                tmo <= tmo - 1'b1;
            case (state)
                IDLE: if (rx_valid) begin
                    cmd   <= rx_byte;
                    cnt   <= '0;
                    csum  <= '0;
                    state <= ADDR;
                end
                ADDR: if (rx_valid) begin
                    abuf <= ab_n;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'(AB - 1)) begin
                        cnt   <= '0;
                        state <= SIZE;
                    end
                end
                SIZE: if (rx_valid) begin
                    size <= sz_n;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd1) begin
                        cnt <= '0;
                        if (is_wr || is_rd) begin
                            mem_addr <= ADDR_WIDTH'(abuf);
                            mem_sel  <= (cmd == 8'd3 || cmd == 8'd4) ? 2'd1 : cmd == 8'd6 ? 2'd2 : 2'd0;
                        end
                        if (is_wr)
                            state <= sz_n != '0 ? WR_DATA : CSUM ? WR_CSUM : IDLE;
                        else if (is_rd && sz_n != '0) begin
                            mem_rden <= 1'b1;
                            state    <= RD_ISSUE;
                        end else if (is_rd && CSUM) begin
                            tx_byte  <= '0;
                            tx_valid <= 1'b1;
                            state    <= CS_SEND;
                        end else
                            state <= is_rd ? IDLE : EXEC;
                    end
                end
                EXEC: begin
                    if (cmd == 8'd0) leds <= size[7:0];
                    if (cmd == 8'd5) processor_reset <= size[0];
                    continue_pulse <= cmd == 8'd7;
                    state          <= IDLE;
                end
                WR_DATA: if (mem_wren) begin
                    mem_wren <= 1'b0;
                    mem_addr <= mem_addr + 1'b1;
                    size     <= size - 16'd1;
                    if (size == 16'd1) state <= CSUM ? WR_CSUM : IDLE;
                end else if (rx_valid) begin
                    wbuf <= wb_n;
                    csum <= csum ^ rx_byte;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'(NB - 1)) begin
                        cnt       <= '0;
                        mem_wdata <= WORD_SIZE'(wb_n);
                        mem_wren  <= 1'b1;
                    end
                end
                WR_CSUM: if (rx_valid) begin
                    tx_byte  <= rx_byte == csum ? 8'hA5 : 8'h5A;
                    tx_valid <= 1'b1;
                    state    <= CS_SEND;
                end
                RD_ISSUE: begin
                    cnt   <= 3'(READ_LATENCY - 1);
                    state <= RD_WAIT;
                end
                RD_WAIT: if (cnt == '0) begin
                    sh       <= rd_ext;
                    tx_byte  <= rd_ext[7:0];
                    tx_valid <= 1'b1;
                    state    <= RD_SEND;
                end else
                    cnt <= cnt - 3'd1;
                RD_SEND: if (tx_valid && tx_ready) begin
                    csum    <= csum ^ tx_byte;
                    sh      <= sh >> 8;
                    tx_byte <= sh[15:8];
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'(NB - 1)) begin
                        cnt      <= '0;
                        mem_addr <= mem_addr + 1'b1;
                        size     <= size - 16'd1;
                        if (size != 16'd1) begin
                            tx_valid <= 1'b0;
                            mem_rden <= 1'b1;
                            state    <= RD_ISSUE;
                        end else if (CSUM) begin
                            tx_byte <= csum ^ tx_byte;
                            state   <= CS_SEND;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                CS_SEND: if (tx_valid && tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (tmo_run && !rx_valid && !mem_wren && tmo <= TW'(1))
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_uart_debug_link.sv
// tb_uart_debug_link: directed + randomized bench for uart_debug_link against a byte-level reference model
module tb_uart_debug_link;
    localparam int WS = 18, AW = 16, RL = 2, TO = 300, NB = 3;
    localparam logic [31:0] MASK = (32'd1 << WS) - 32'd1;

    logic          clk_50M = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, tx_ready = 1'b1;
    logic [7:0]    rx_byte = 8'd0;
    logic          tx_valid, mem_wren, mem_rden, processor_reset, continue_pulse, busy;
    logic [7:0]    tx_byte, leds;
    logic [1:0]    mem_sel;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_wdata, mem_rdata = '0;

    int n_tests = 0, n_fail = 0, cp_cnt = 0;
    logic [WS-1:0] data_mem [65536];
    logic [WS-1:0] code_mem [65536];
    logic [WS-1:0] dbg_mem  [256];
    logic [WS-1:0] pipe [RL];
    logic          rd_req = 1'b0;
    logic [WS-1:0] rd_val = '0;
    bit            rnd_rdy = 1'b0, hold_rdy = 1'b0;
    logic [7:0]    txq[$], expq[$];
    logic [63:0]   wrq[$], expw[$];
    logic [AW-1:0] rdq[$], rdx[$];

    uart_debug_link #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .TIMEOUT_CLKS(TO)) dut (
        .clk_50M(clk_50M), .reset_n(reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_rdata(mem_rdata), .leds(leds), .processor_reset(processor_reset),
        .continue_pulse(continue_pulse), .busy(busy)
    );

    always #5 clk_50M = ~clk_50M;

    function automatic logic [WS-1:0] lookup(input logic [1:0] s, input logic [AW-1:0] a);
        return s == 2'd0 ? data_mem[a] : s == 2'd1 ? code_mem[a] : s == 2'd2 ? dbg_mem[a[7:0]] : '0;
    endfunction

    // Observe DUT outputs mid-cycle: handshakes, strobes and read requests
    always @(negedge clk_50M) begin
        rd_req = mem_rden;
        rd_val = lookup(mem_sel, mem_addr);
        if (tx_valid && tx_ready) txq.push_back(tx_byte);
        if (mem_wren) wrq.push_back(64'({mem_sel, mem_addr, mem_wdata}));
        if (mem_rden) rdq.push_back(mem_addr);
        if (continue_pulse) cp_cnt++;
    end

    // Memory with READ_LATENCY pipeline (garbage when no request) and transmitter ready
    always @(posedge clk_50M) begin
        #1;
        for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = rd_req ? rd_val : WS'($urandom);
        mem_rdata = pipe[RL-1];
        tx_ready = hold_rdy ? 1'b0 : rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk_50M); #1 rx_valid = 1'b1; rx_byte = b;
        @(posedge clk_50M); #1 rx_valid = 1'b0;
        tick(2);
    endtask

    task automatic frame(input logic [7:0] c, input logic [15:0] a, input logic [15:0] sz);
        send(c); send(a[7:0]); send(a[15:8]); send(sz[7:0]); send(sz[15:8]);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk_50M);
        while (busy !== 1'b0 && k < 5000) begin @(negedge clk_50M); k++; end
        chk({tag, " idle"}, 32'(busy), 32'd0);
        tick(2);
    endtask

    task automatic exp_read(input logic [1:0] s, input logic [AW-1:0] a, input int n);
        logic [7:0] x;
        logic [31:0] w;
        logic [AW-1:0] ak;
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + AW'(k);
            w = 32'(lookup(s, ak)) & MASK;
            rdx.push_back(ak);
            for (int j = 0; j < NB; j++) begin
                expq.push_back(w[8*j +: 8]);
                x ^= w[8*j +: 8];
            end
        end
`ifdef UART_DEBUG_LINK_CHECKSUM_EN
        expq.push_back(x);
`endif
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, " tx count"}, 32'(txq.size()), 32'(expq.size()));
        for (int i = 0; i < txq.size() && i < expq.size(); i++)
            chk($sformatf("%s tx[%0d]", tag, i), 32'(txq[i]), 32'(expq[i]));
        chk({tag, " wr count"}, 32'(wrq.size()), 32'(expw.size()));
        for (int i = 0; i < wrq.size() && i < expw.size(); i++)
            chk($sformatf("%s wr[%0d]", tag, i), 32'(wrq[i]), 32'(expw[i]));
        chk({tag, " rd count"}, 32'(rdq.size()), 32'(rdx.size()));
        for (int i = 0; i < rdq.size() && i < rdx.size(); i++)
            chk($sformatf("%s rd[%0d]", tag, i), 32'(rdq[i]), 32'(rdx[i]));
        txq.delete(); expq.delete(); wrq.delete(); expw.delete(); rdq.delete(); rdx.delete();
    endtask

    initial begin
        logic [7:0] b0, b1, b2, x, c, led_s;
        logic [15:0] a;
        logic [1:0] s;
        int n, cp_s;
        logic pr_s;

        tick(3);
        @(negedge clk_50M);
        chk("reset leds", 32'(leds), 32'd0);
        chk("reset processor_reset", 32'(processor_reset), 32'd1);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset strobes", 32'({mem_wren, mem_rden, continue_pulse}), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset tx_byte", 32'(tx_byte), 32'd0);
        @(posedge clk_50M); #1 reset_n = 1'b1;
        tick(2);

        frame(8'h00, 16'h0000, 16'h003C);
        chk("leds 3C", 32'(leds), 32'h3C);
        chk("leds busy", 32'(busy), 32'd0);
        for (int r = 0; r < 3; r++) begin
            b0 = 8'($urandom);
            frame(8'h00, 16'($urandom), {8'($urandom), b0});
            chk("leds random", 32'(leds), 32'(b0));
        end

        frame(8'h01, 16'h0010, 16'd2);
        send(8'h05); send(8'h00); send(8'h02);
        send(8'h07); send(8'h80); send(8'h03);
        expw.push_back(64'({2'd0, 16'h0010, 18'h20005}));
        expw.push_back(64'({2'd0, 16'h0011, 18'h38007}));
`ifdef UART_DEBUG_LINK_CHECKSUM_EN
        send(8'h83);
        expq.push_back(8'hA5);
`endif
        wait_idle("plan write");
        cmp_all("plan write");

        for (int r = 0; r < 3; r++) begin
            c = $urandom_range(0, 1) ? 8'h01 : 8'h03;
            s = c == 8'h01 ? 2'd0 : 2'd1;
            a = 16'($urandom);
            n = $urandom_range(1, 3);
            x = 8'd0;
            frame(c, a, 16'(n));
            for (int k = 0; k < n; k++) begin
                b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
                send(b0); send(b1); send(b2);
                x ^= b0 ^ b1 ^ b2;
                expw.push_back(64'({s, a + 16'(k), 18'(32'({b2, b1, b0}) & MASK)}));
            end
`ifdef UART_DEBUG_LINK_CHECKSUM_EN
            send(x);
            expq.push_back(8'hA5);
`endif
            wait_idle("rand write");
            cmp_all("rand write");
        end

        code_mem[16'hFFFF] = 18'h3ABCD;
        code_mem[16'h0000] = 18'h00001;
        for (int r = 0; r < 2; r++) begin
            rnd_rdy = r == 1;
            frame(8'h04, 16'hFFFF, 16'd2);
            wait_idle("plan read");
            expq = '{8'hCD, 8'hAB, 8'h03, 8'h01, 8'h00, 8'h00};
`ifdef UART_DEBUG_LINK_CHECKSUM_EN
            expq.push_back(8'h64);
`endif
            rdx = '{16'hFFFF, 16'h0000};
            cmp_all(r == 1 ? "plan read rdy" : "plan read");
        end

        for (int r = 0; r < 4; r++) begin
            c = r == 0 ? 8'h06 : 8'(2 * $urandom_range(1, 3));
            s = c == 8'h02 ? 2'd0 : c == 8'h04 ? 2'd1 : 2'd2;
            a = 16'($urandom);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                data_mem[a + 16'(k)] = WS'($urandom);
                code_mem[a + 16'(k)] = WS'($urandom);
                dbg_mem[8'(a + 16'(k))] = WS'($urandom);
            end
            rnd_rdy = 1'($urandom_range(0, 1));
            frame(c, a, 16'(n));
            wait_idle("rand read");
            exp_read(s, a, n);
            cmp_all($sformatf("rand read cmd%0d", c));
        end
        rnd_rdy = 1'b0;

        frame(8'h02, 16'h1234, 16'd0);
        wait_idle("read size0");
`ifdef UART_DEBUG_LINK_CHECKSUM_EN
        expq.push_back(8'h00);
`endif
        cmp_all("read size0");

        frame(8'h03, 16'h0000, 16'd1);
        send(8'h11);
        tick(TO + 10);
        @(negedge clk_50M);
        chk("timeout busy", 32'(busy), 32'd0);
        cmp_all("timeout");
        frame(8'h00, 16'h0000, 16'd1);
        chk("after timeout leds", 32'(leds), 32'd1);

        frame(8'h05, 16'h0000, 16'd0);
        chk("proc reset 0", 32'(processor_reset), 32'd0);
        cp_cnt = 0;
        frame(8'h07, 16'h0000, 16'd0);
        chk("continue pulse once", 32'(cp_cnt), 32'd1);
        frame(8'h05, 16'h0000, 16'd1);
        chk("proc reset 1", 32'(processor_reset), 32'd1);

        led_s = leds; pr_s = processor_reset; cp_s = cp_cnt;
        frame(8'h55, 16'($urandom), 16'($urandom));
        tick(2);
        chk("unknown leds", 32'(leds), 32'(led_s));
        chk("unknown proc reset", 32'(processor_reset), 32'(pr_s));
        chk("unknown continue", 32'(cp_cnt), 32'(cp_s));
        chk("unknown busy", 32'(busy), 32'd0);
        cmp_all("unknown");

`ifdef UART_DEBUG_LINK_CHECKSUM_EN
        for (int r = 0; r < 2; r++) begin
            a = 16'($urandom);
            frame(8'h01, a, 16'd1);
            send(8'h01); send(8'h02); send(8'h00);
            send(r == 0 ? 8'h03 : 8'h04);
            expw.push_back(64'({2'd0, a, 18'h00201}));
            expq.push_back(r == 0 ? 8'hA5 : 8'h5A);
            wait_idle("csum write");
            cmp_all(r == 0 ? "csum good" : "csum bad");
        end
        frame(8'h01, 16'h0000, 16'd0);
        send(8'h00);
        expq.push_back(8'hA5);
        wait_idle("csum size0");
        cmp_all("csum size0 write");
`endif

        frame(8'h00, 16'h0000, 16'h00F0);
        hold_rdy = 1'b1;
        frame(8'h02, 16'h0020, 16'd1);
        tick(RL + 4);
        @(negedge clk_50M);
        chk("midburst tx_valid held", 32'(tx_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midburst reset tx_valid", 32'(tx_valid), 32'd0);
        chk("midburst reset busy", 32'(busy), 32'd0);
        chk("midburst reset leds", 32'(leds), 32'd0);
        chk("midburst reset proc", 32'(processor_reset), 32'd1);
        hold_rdy = 1'b0;
        tick(3);
        @(negedge clk_50M);
        chk("reset no strobes", 32'({mem_wren, mem_rden, tx_valid}), 32'd0);
        @(posedge clk_50M); #1 reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
